// File: rtl/os_pfb_deadlock_detect_unit.sv
// ----------------------------------------------------------------------------
// os_pfb_deadlock_detect_unit
//   Per-process deadlock detector for the os_pfb C/RTL cosim bench. Watches the
//   monitored process's blocking handshakes. After a sustained identical stall
//   it sends a probe token along its wait edges. If the probe comes back, it
//   reports the closed wait loop on dl_out. Once deadlocked, it forwards trace
//   tokens so the report unit can print the wait circle hop by hop.
//
// Ports
//   clock          in   1         bench clock, rising edge
//   reset          in   1         asynchronous, active-low
//   proc_blocked   in   1         monitored process has a blk_n low this cycle
//   dep_vec        in   PROC_NUM  bit j: blocked on a FIFO shared with proc j
//   probe_in_vec   in   PROC_NUM  bit j: probe token from proc j
//   probe_out_vec  out  PROC_NUM  probe tokens to procs (registered)
//   trace_in_vec   in   PROC_NUM  bit j: trace token from proc j
//   trace_out_vec  out  PROC_NUM  one-hot trace token to next proc (registered)
//   origin         in   1         report unit picks this proc as circle origin
//   token_clear    in   1         report unit circle-done strobe
//   dl_out         out  1         deadlock / trace-hit report (combinational)
//   dl_state       out  2         current FSM state (debug)
// ----------------------------------------------------------------------------
module os_pfb_deadlock_detect_unit #(
  parameter int unsigned PROC_NUM     = 3,
  parameter int unsigned PROC_ID      = 0,
  parameter int unsigned STALL_THRESH = 16,
  parameter int unsigned PROBE_TMO    = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                proc_blocked,
  input  logic [PROC_NUM-1:0] dep_vec,
  input  logic [PROC_NUM-1:0] probe_in_vec,
  output logic [PROC_NUM-1:0] probe_out_vec,
  input  logic [PROC_NUM-1:0] trace_in_vec,
  output logic [PROC_NUM-1:0] trace_out_vec,
  input  logic                origin,
  input  logic                token_clear,
  output logic                dl_out,
  output logic [1:0]          dl_state
);

  localparam int unsigned CNT_W = $clog2(STALL_THRESH + 1);
  localparam int unsigned TMO_W = $clog2(PROBE_TMO + 1);

  localparam logic [PROC_NUM-1:0] SELF_MASK = PROC_NUM'(1) << PROC_ID;
  localparam logic [CNT_W-1:0]    CNT_SAT   = CNT_W'(STALL_THRESH);
  localparam logic [CNT_W-1:0]    CNT_FIRE  = CNT_W'(STALL_THRESH - 1);
  localparam logic [TMO_W-1:0]    TMO_LAST  = TMO_W'(PROBE_TMO - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STALL    = 2'd1,
    ST_SUSPECT  = 2'd2,
    ST_DEADLOCK = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [PROC_NUM-1:0] dep_reg_q;
  logic [PROC_NUM-1:0] probe_q, probe_d;
  logic [PROC_NUM-1:0] trace_q, trace_d;
  logic                det_q, det_d;

  logic [PROC_NUM-1:0] dep_eff;
  logic [PROC_NUM-1:0] dep_low;
  logic                blocked;
  logic                probe_hit;
  logic                trace_hit;

  // A self-loop on our own FIFO is not a dependency on another process.
  assign dep_eff   = dep_vec & ~SELF_MASK;
  assign blocked   = proc_blocked & (|dep_eff);
  assign probe_hit = |probe_in_vec;
  assign trace_hit = |trace_in_vec;
  // Lowest set bit picks a single successor for the trace walk.
  assign dep_low   = dep_reg_q & (~dep_reg_q + PROC_NUM'(1));

  // State and token registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      dep_reg_q   <= '0;
      probe_q     <= '0;
      trace_q     <= '0;
      det_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      dep_reg_q   <= dep_eff;
      probe_q     <= probe_d;
      trace_q     <= trace_d;
      det_q       <= det_d;
    end
  end

  // Next-state, counters and token generation.
  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = '0;
    probe_d   = '0;
    trace_d   = '0;
    det_d     = 1'b0;

    // Only an unchanged blocking pattern counts as a stall.
    if (!blocked || (dep_eff != dep_reg_q)) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q != CNT_SAT) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end

    case (state_q)
      ST_RUN: begin
        if (blocked) begin
          state_d = ST_STALL;
        end
      end
      ST_STALL: begin
        if (!blocked) begin
          state_d = ST_RUN;
        end else begin
          if (stall_cnt_q == CNT_FIRE) begin
            state_d = ST_SUSPECT;
            probe_d = dep_reg_q;
          end
          if (probe_hit) begin
            probe_d = dep_reg_q;
          end
        end
      end
      ST_SUSPECT: begin
        // Incoming probes are consumed here; any return closes the loop.
        if (!blocked) begin
          state_d = ST_RUN;
        end else if (probe_hit) begin
          state_d = ST_DEADLOCK;
          det_d   = 1'b1;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d     = ST_STALL;
          stall_cnt_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      ST_DEADLOCK: begin
        // Sticky; keep relaying probes so peers can confirm the loop too.
        if (probe_hit) begin
          probe_d = dep_reg_q;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Origin outranks a forwarded token so only one token leaves.
    if (origin && (state_q == ST_DEADLOCK)) begin
      trace_d = dep_low;
    end else if (trace_hit && !token_clear) begin
      trace_d = dep_low;
    end
  end

  assign probe_out_vec = probe_q;
  assign trace_out_vec = trace_q;
  assign dl_state      = state_q;
  assign dl_out        = det_q | ((state_q == ST_DEADLOCK) & trace_hit);

endmodule

// File: tb/tb_os_pfb_deadlock_detect_unit.sv
// ----------------------------------------------------------------------------
// tb_os_pfb_deadlock_detect_unit
//   Directed bench for os_pfb_deadlock_detect_unit (PROC_NUM=3, PROC_ID=0,
//   STALL_THRESH=16, PROBE_TMO=4). Each step drives inputs, queues the
//   expected outputs for that cycle and checks them mid-cycle.
// ----------------------------------------------------------------------------
module tb_os_pfb_deadlock_detect_unit;

  logic       clock;
  logic       reset;
  logic       proc_blocked;
  logic [2:0] dep_vec;
  logic [2:0] probe_in_vec;
  logic [2:0] probe_out_vec;
  logic [2:0] trace_in_vec;
  logic [2:0] trace_out_vec;
  logic       origin;
  logic       token_clear;
  logic       dl_out;
  logic [1:0] dl_state;

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic [2:0] probe;
    logic [2:0] trace;
    logic       dl;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  os_pfb_deadlock_detect_unit #(
    .PROC_NUM(3), .PROC_ID(0), .STALL_THRESH(16), .PROBE_TMO(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .proc_blocked(proc_blocked),
    .dep_vec(dep_vec),
    .probe_in_vec(probe_in_vec),
    .probe_out_vec(probe_out_vec),
    .trace_in_vec(trace_in_vec),
    .trace_out_vec(trace_out_vec),
    .origin(origin),
    .token_clear(token_clear),
    .dl_out(dl_out),
    .dl_state(dl_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic push_exp(input string tag, input logic [1:0] st,
                          input logic [2:0] probe, input logic [2:0] trace,
                          input logic dl);
    exp_t e;
    e.tag = tag; e.st = st; e.probe = probe; e.trace = trace; e.dl = dl;
    sb_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    e = sb_q.pop_front();
    n_tests++;
    assert (dl_state === e.st) else begin
      n_fail++; $error("FAIL %s dl_state got %0d exp %0d", e.tag, dl_state, e.st);
    end
    n_tests++;
    assert (probe_out_vec === e.probe) else begin
      n_fail++; $error("FAIL %s probe_out got %b exp %b", e.tag, probe_out_vec, e.probe);
    end
    n_tests++;
    assert (trace_out_vec === e.trace) else begin
      n_fail++; $error("FAIL %s trace_out got %b exp %b", e.tag, trace_out_vec, e.trace);
    end
    n_tests++;
    assert (dl_out === e.dl) else begin
      n_fail++; $error("FAIL %s dl_out got %b exp %b", e.tag, dl_out, e.dl);
    end
  endtask

  // Called at posedge+1: drive, queue expectation, check at negedge, advance.
  task automatic step(input logic blk, input logic [2:0] dep, input logic [2:0] pin,
                      input logic [2:0] tin, input logic org, input logic clr,
                      input logic [1:0] est, input logic [2:0] eprobe,
                      input logic [2:0] etrace, input logic edl, input string tag);
    proc_blocked = blk; dep_vec = dep; probe_in_vec = pin;
    trace_in_vec = tin; origin = org; token_clear = clr;
    push_exp(tag, est, eprobe, etrace, edl);
    #4;
    check_out();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    proc_blocked = 1'b0; dep_vec = '0; probe_in_vec = '0;
    trace_in_vec = '0; origin = 1'b0; token_clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    push_exp(tag, 2'd0, 3'b000, 3'b000, 1'b0);
    check_out();
    reset = 1'b1;
  endtask

  // Expected state for a stall that started at cycle 0 and loops every 20.
  function automatic logic [1:0] exp_stall_state(input int c);
    int k;
    if (c == 0) return 2'd0;
    k = (c - 1) % 20;
    return (k < 16) ? 2'd1 : 2'd2;
  endfunction

  initial begin
    reset = 1'b0;
    proc_blocked = 1'b0; dep_vec = '0; probe_in_vec = '0;
    trace_in_vec = '0; origin = 1'b0; token_clear = 1'b0;
    #1;

    // T1: probe returns two cycles after emission -> deadlock.
    do_reset("T1 reset");
    for (int c = 0; c <= 22; c++) begin
      step(1'b1, 3'b010, (c == 19) ? 3'b010 : 3'b000, 3'b000, 1'b0, 1'b0,
           (c == 0) ? 2'd0 : (c <= 16) ? 2'd1 : (c <= 19) ? 2'd2 : 2'd3,
           (c == 17) ? 3'b010 : 3'b000, 3'b000, (c == 20), "T1");
    end

    // T2: no return -> 4-cycle suspect window, re-probe every 20 cycles.
    do_reset("T2 reset");
    for (int c = 0; c <= 58; c++) begin
      step(1'b1, 3'b010, 3'b000, 3'b000, 1'b0, 1'b0, exp_stall_state(c),
           (c > 0 && ((c - 1) % 20) == 16) ? 3'b010 : 3'b000, 3'b000, 1'b0, "T2");
    end

    // T3: dependency change restarts the stall count.
    do_reset("T3 reset");
    for (int c = 0; c <= 28; c++) begin
      step(1'b1, (c < 10) ? 3'b010 : 3'b100, 3'b000, 3'b000, 1'b0, 1'b0,
           (c == 0) ? 2'd0 : (c <= 26) ? 2'd1 : 2'd2,
           (c == 27) ? 3'b100 : 3'b000, 3'b000, 1'b0, "T3");
    end

    // T4: deadlock with dep 110 (self bit masked), then trace handling.
    do_reset("T4 reset");
    for (int c = 0; c <= 20; c++) begin
      step(1'b1, 3'b111, (c == 19) ? 3'b100 : 3'b000, 3'b000, 1'b0, 1'b0,
           (c == 0) ? 2'd0 : (c <= 16) ? 2'd1 : (c <= 19) ? 2'd2 : 2'd3,
           (c == 17) ? 3'b110 : 3'b000, 3'b000, (c == 20), "T4 detect");
    end
    step(1'b1, 3'b110, 3'b000, 3'b000, 1'b1, 1'b0, 2'd3, 3'b000, 3'b000, 1'b0, "T4 origin");
    step(1'b1, 3'b110, 3'b000, 3'b000, 1'b0, 1'b0, 2'd3, 3'b000, 3'b010, 1'b0, "T4 trace_out");
    step(1'b1, 3'b110, 3'b000, 3'b100, 1'b0, 1'b1, 2'd3, 3'b000, 3'b000, 1'b1, "T4 clear dl");
    step(1'b1, 3'b110, 3'b000, 3'b000, 1'b0, 1'b0, 2'd3, 3'b000, 3'b000, 1'b0, "T4 cleared");
    step(1'b1, 3'b110, 3'b000, 3'b001, 1'b0, 1'b0, 2'd3, 3'b000, 3'b000, 1'b1, "T4 trace_in");
    step(1'b1, 3'b110, 3'b000, 3'b000, 1'b0, 1'b0, 2'd3, 3'b000, 3'b010, 1'b0, "T4 forward");
    step(1'b1, 3'b110, 3'b000, 3'b100, 1'b1, 1'b0, 2'd3, 3'b000, 3'b000, 1'b1, "T4 both");
    step(1'b1, 3'b110, 3'b000, 3'b000, 1'b0, 1'b0, 2'd3, 3'b000, 3'b010, 1'b0, "T4 single tok");
    step(1'b0, 3'b110, 3'b010, 3'b000, 1'b0, 1'b0, 2'd3, 3'b000, 3'b000, 1'b0, "T4 sticky");
    step(1'b0, 3'b110, 3'b000, 3'b000, 1'b0, 1'b0, 2'd3, 3'b110, 3'b000, 1'b0, "T4 dl probe fwd");
    step(1'b0, 3'b110, 3'b000, 3'b000, 1'b0, 1'b0, 2'd3, 3'b000, 3'b000, 1'b0, "T4 probe 1cyc");

    // T5: probe forwarding in STALL, unblock beats probe, RUN drops probes.
    do_reset("T5 reset");
    for (int c = 0; c <= 4; c++) begin
      step(1'b1, 3'b010, (c == 2) ? 3'b001 : 3'b000, 3'b000, 1'b0, 1'b0,
           (c == 0) ? 2'd0 : 2'd1, (c == 3) ? 3'b010 : 3'b000, 3'b000, 1'b0, "T5 fwd");
    end
    step(1'b0, 3'b010, 3'b001, 3'b000, 1'b0, 1'b0, 2'd1, 3'b000, 3'b000, 1'b0, "T5 unblock");
    step(1'b0, 3'b010, 3'b010, 3'b000, 1'b1, 1'b0, 2'd0, 3'b000, 3'b000, 1'b0, "T5 dropped");
    step(1'b0, 3'b010, 3'b000, 3'b000, 1'b0, 1'b0, 2'd0, 3'b000, 3'b000, 1'b0, "T5 run drop");

    // T6: asynchronous reset while the probe is on the wire.
    do_reset("T6 reset");
    for (int c = 0; c <= 16; c++) begin
      step(1'b1, 3'b010, 3'b000, 3'b000, 1'b0, 1'b0, exp_stall_state(c),
           3'b000, 3'b000, 1'b0, "T6 stall");
    end
    push_exp("T6 suspect", 2'd2, 3'b010, 3'b000, 1'b0);
    #4;
    check_out();
    #1;
    trace_in_vec = 3'b010;
    reset = 1'b0;
    #1;
    push_exp("T6 async", 2'd0, 3'b000, 3'b000, 1'b0);
    check_out();
    do_reset("T6 held");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
